// File: rtl/ulap_palette_loader_pkg.sv
// Shared types and constants for the ULA+ palette upload sequencer.
package ulap_palette_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        FETCH,
        T1,
        T2,
        TW,
        T3
    } ulap_state_e;

    localparam logic [15:0] ULAP_SEL_PORT  = 16'hBF3B;
    localparam logic [15:0] ULAP_DATA_PORT = 16'hFF3B;
    localparam int unsigned ULAP_WRITES    = 130;
    localparam logic [7:0]  ULAP_LAST_WR   = 8'(ULAP_WRITES - 1);

endpackage

// File: rtl/ulap_palette_loader.sv
// Uploads a 64-entry ULA+ palette plus the mode group as Z80-style I/O writes,
// one select/data port pair per entry.
//
// state | meaning
// IDLE  | waiting for start
// REQ   | bus_req raised, waiting for bus_ack
// FETCH | load io_addr/io_dout for the current write
// T1    | address/data valid, strobes high
// T2    | nIORQ/nWR low
// TW    | wait state, strobes still low
// T3    | strobes high, decide next write / finish / abort
module ulap_palette_loader
    import ulap_palette_loader_pkg::*;
(
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic        ce,
    input  logic        start,
    input  logic        abort,
    input  logic        cfg_ena,
    input  logic        cfg_mono,
    input  logic [5:0]  cfg_tmx,
    output logic [5:0]  src_addr,
    input  logic [7:0]  src_data,
    output logic        bus_req,
    input  logic        bus_ack,
    output logic [15:0] io_addr,
    output logic [7:0]  io_dout,
    output logic        nIORQ,
    output logic        nWR,
    output logic        busy,
    output logic        done,
    output logic        aborted
);

    logic [1:0]  rst_sync_q;
    logic        rst_int_n;

    ulap_state_e state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        ena_q, ena_d;
    logic        mono_q, mono_d;
    logic [5:0]  tmx_q, tmx_d;
    logic [15:0] io_addr_q, io_addr_d;
    logic [7:0]  io_dout_q, io_dout_d;
    logic        done_q, done_d;
    logic        aborted_q, aborted_d;
    logic [7:0]  payload;

    // Assertion is asynchronous, release is retimed to clk_sys.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync_q[1];

    always_ff @(posedge clk_sys or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            abort_q   <= 1'b0;
            ena_q     <= 1'b0;
            mono_q    <= 1'b0;
            tmx_q     <= '0;
            io_addr_q <= '0;
            io_dout_q <= '0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            abort_q   <= abort_d;
            ena_q     <= ena_d;
            mono_q    <= mono_d;
            tmx_q     <= tmx_d;
            io_addr_q <= io_addr_d;
            io_dout_q <= io_dout_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    // Data writes read the entry selected a whole write earlier, so src_data is settled by FETCH.
    always_comb begin
        payload = '0;
        if (cnt_q[7]) begin
            payload = cnt_q[0] ? {6'b0, mono_q, ena_q} : {2'b01, tmx_q};
        end else begin
            payload = cnt_q[0] ? src_data : {2'b00, cnt_q[6:1]};
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        abort_d   = abort_q;
        ena_d     = ena_q;
        mono_d    = mono_q;
        tmx_d     = tmx_q;
        io_addr_d = io_addr_q;
        io_dout_d = io_dout_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;

        if (state_q != IDLE && abort) begin
            abort_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    cnt_d   = '0;
                    abort_d = 1'b0;
                    ena_d   = cfg_ena;
                    mono_d  = cfg_mono;
                    tmx_d   = cfg_tmx;
                end
            end
            REQ: begin
                if (abort_q || abort) begin
                    state_d   = IDLE;
                    abort_d   = 1'b0;
                    aborted_d = 1'b1;
                end else if (ce && bus_ack) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                io_addr_d = cnt_q[0] ? ULAP_DATA_PORT : ULAP_SEL_PORT;
                io_dout_d = payload;
                state_d   = T1;
            end
            T1: if (ce) state_d = T2;
            T2: if (ce) state_d = TW;
            TW: if (ce) state_d = T3;
            T3: begin
                if (ce) begin
                    if (abort_q || abort) begin
                        state_d   = IDLE;
                        abort_d   = 1'b0;
                        aborted_d = 1'b1;
                    end else if (cnt_q == ULAP_LAST_WR) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + 8'd1;
                        state_d = FETCH;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign src_addr = cnt_q[7] ? 6'd63 : cnt_q[6:1];
    assign busy     = (state_q != IDLE);
    assign bus_req  = (state_q != IDLE);
    assign nIORQ    = !(state_q == T2 || state_q == TW);
    assign nWR      = !(state_q == T2 || state_q == TW);
    assign io_addr  = io_addr_q;
    assign io_dout  = io_dout_q;
    assign done     = done_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_ulap_palette_loader.sv
// Directed bench for the ULA+ palette loader with a behavioural ULA+ responder
// and a registered palette source ROM.
module tb_ulap_palette_loader;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        start;
    logic        abort;
    logic        cfg_ena;
    logic        cfg_mono;
    logic [5:0]  cfg_tmx;
    logic [5:0]  src_addr;
    logic [7:0]  src_data;
    logic        bus_req;
    logic        bus_ack;
    logic [15:0] io_addr;
    logic [7:0]  io_dout;
    logic        nIORQ;
    logic        nWR;
    logic        busy;
    logic        done;
    logic        aborted;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ce_period = 1;
    logic [7:0] key = 8'hA0;
    logic clr_resp = 1'b0;
    int exp_low = 2;
    int exp_gap = 5;

    // responder state
    logic [7:0]  pal [64];
    logic [7:0]  sel_r;
    logic        r_ena, r_mono;
    logic [5:0]  r_tmx;
    logic        prev_nio;
    logic [23:0] held;
    int wr_count, low_len, low_bad, gap_bad, chg_bad, strobe_bad;
    int done_cnt, aborted_cnt, done_busy, clk_n, last_onset;
    logic have_prev;

    ulap_palette_loader dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ce      (ce),
        .start   (start),
        .abort   (abort),
        .cfg_ena (cfg_ena),
        .cfg_mono(cfg_mono),
        .cfg_tmx (cfg_tmx),
        .src_addr(src_addr),
        .src_data(src_data),
        .bus_req (bus_req),
        .bus_ack (bus_ack),
        .io_addr (io_addr),
        .io_dout (io_dout),
        .nIORQ   (nIORQ),
        .nWR     (nWR),
        .busy    (busy),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clk_sys = ~clk_sys;

    always @(posedge clk_sys) src_data <= key ^ {2'b00, src_addr};

    always @(posedge clk_sys) begin
        clk_n    <= clk_n + 1;
        prev_nio <= nIORQ;
        if (clr_resp) begin
            for (int i = 0; i < 64; i++) pal[i] <= 8'h00;
            sel_r <= 8'h00; r_ena <= 1'b0; r_mono <= 1'b0; r_tmx <= 6'h00;
            wr_count <= 0; low_len <= 0; low_bad <= 0; gap_bad <= 0; chg_bad <= 0;
            strobe_bad <= 0; done_cnt <= 0; aborted_cnt <= 0; done_busy <= 0;
            have_prev <= 1'b0;
        end else begin
            if (done) done_cnt <= done_cnt + 1;
            if (aborted) aborted_cnt <= aborted_cnt + 1;
            if (done && busy) done_busy <= done_busy + 1;
            if (nWR !== nIORQ) strobe_bad <= strobe_bad + 1;
            if (!nIORQ) begin
                if (prev_nio) begin
                    wr_count   <= wr_count + 1;
                    low_len    <= 1;
                    held       <= {io_addr, io_dout};
                    last_onset <= clk_n;
                    have_prev  <= 1'b1;
                    if (have_prev && (clk_n - last_onset) != exp_gap) gap_bad <= gap_bad + 1;
                    if (io_addr == 16'hBF3B) begin
                        sel_r <= io_dout;
                    end else if (io_addr == 16'hFF3B) begin
                        if (sel_r[7:6] == 2'b00) pal[sel_r[5:0]] <= io_dout;
                        else if (sel_r[7:6] == 2'b01) begin
                            r_ena <= io_dout[0]; r_mono <= io_dout[1]; r_tmx <= sel_r[5:0];
                        end
                    end
                end else begin
                    low_len <= low_len + 1;
                    if ({io_addr, io_dout} != held) chg_bad <= chg_bad + 1;
                end
            end else if (!prev_nio) begin
                if (low_len != exp_low) low_bad <= low_bad + 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
        cyc++;
        ce = (ce_period <= 1) || ((cyc % ce_period) == 0);
    endtask

    task automatic clear_resp();
        clr_resp = 1'b1;
        tick();
        clr_resp = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int n = 0; n < budget; n++) begin
            tick();
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    function automatic int pal_errs(input logic [7:0] k);
        int e = 0;
        for (int i = 0; i < 64; i++) begin
            if (pal[i] !== (k ^ 8'(i))) e++;
        end
        return e;
    endfunction

    initial begin
        logic ok;
        reset_n = 1'b0; ce = 1'b1; start = 1'b0; abort = 1'b0;
        cfg_ena = 1'b0; cfg_mono = 1'b0; cfg_tmx = 6'h00; bus_ack = 1'b0;
        clk_n = 0; last_onset = 0;
        clear_resp();
        tick(); tick();
        chk("rst_busy", busy, 0);
        chk("rst_nIORQ", nIORQ, 1);
        chk("rst_nWR", nWR, 1);
        chk("rst_bus_req", bus_req, 0);
        reset_n = 1'b1;
        tick(); tick(); tick();
        chk("rst_io_addr", io_addr, 0);
        chk("rst_io_dout", io_dout, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("rst_done", done, 0);

        // full upload, ce every clock
        key = 8'hA0; cfg_ena = 1'b1; cfg_mono = 1'b0; cfg_tmx = 6'h15; bus_ack = 1'b1;
        exp_low = 2; exp_gap = 5;
        clear_resp();
        pulse_start();
        chk("a_busy", busy, 1);
        wait_idle(2000, ok);
        chk("a_finish", ok, 1);
        chk("a_done_with_busy_fall", done, 1);
        tick(); tick();
        chk("a_writes", wr_count, 130);
        chk("a_palette", pal_errs(8'hA0), 0);
        chk("a_ena", r_ena, 1);
        chk("a_mono", r_mono, 0);
        chk("a_tmx", r_tmx, 6'h15);
        chk("a_done_cnt", done_cnt, 1);
        chk("a_aborted_cnt", aborted_cnt, 0);
        chk("a_done_busy", done_busy, 0);
        chk("a_low_len", low_bad, 0);
        chk("a_gap", gap_bad, 0);
        chk("a_stable", chg_bad, 0);
        chk("a_strobes", strobe_bad, 0);
        chk("a_src_hold", src_addr, 63);
        chk("a_last_addr", io_addr, 16'hFF3B);

        // bus grant delayed 50 clocks, then dropped mid-run
        key = 8'h5C; cfg_ena = 1'b0; cfg_mono = 1'b1; cfg_tmx = 6'h2A; bus_ack = 1'b0;
        clear_resp();
        pulse_start();
        for (int n = 0; n < 50; n++) tick();
        chk("b_no_writes", wr_count, 0);
        chk("b_nIORQ_idle", nIORQ, 1);
        chk("b_bus_req", bus_req, 1);
        bus_ack = 1'b1;
        tick();
        tick();
        chk("b_first_addr", io_addr, 16'hBF3B);
        chk("b_first_data", io_dout, 8'h00);
        chk("b_t1_nIORQ", nIORQ, 1);
        tick();
        chk("b_t2_nIORQ", nIORQ, 0);
        for (int n = 0; n < 20; n++) tick();
        bus_ack = 1'b0;
        wait_idle(2000, ok);
        bus_ack = 1'b1;
        chk("b_finish", ok, 1);
        tick();
        chk("b_writes", wr_count, 130);
        chk("b_palette", pal_errs(8'h5C), 0);
        chk("b_ena", r_ena, 0);
        chk("b_mono", r_mono, 1);
        chk("b_tmx", r_tmx, 6'h2A);

        // abort during TW of write 37
        clear_resp();
        pulse_start();
        ok = 1'b0;
        for (int n = 0; n < 1000; n++) begin
            tick();
            if (wr_count == 38) begin ok = 1'b1; break; end
        end
        chk("c_reach_w37", ok, 1);
        chk("c_in_tw", nIORQ, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("c_t3_busy", busy, 1);
        tick();
        chk("c_aborted_pulse", aborted, 1);
        chk("c_done", done, 0);
        chk("c_busy", busy, 0);
        tick(); tick(); tick();
        chk("c_writes", wr_count, 38);
        chk("c_aborted_cnt", aborted_cnt, 1);
        chk("c_done_cnt", done_cnt, 0);

        // reset during T2 of write 10, then a clean rerun
        clear_resp();
        pulse_start();
        ok = 1'b0;
        for (int n = 0; n < 500; n++) begin
            tick();
            if (wr_count == 10 && !nIORQ) begin ok = 1'b1; break; end
        end
        chk("d_reach_w10", ok, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("d_nIORQ", nIORQ, 1);
        chk("d_nWR", nWR, 1);
        chk("d_busy", busy, 0);
        chk("d_src_addr", src_addr, 0);
        chk("d_io_addr", io_addr, 0);
        tick(); tick();
        reset_n = 1'b1;
        tick(); tick(); tick();
        key = 8'h33;
        clear_resp();
        pulse_start();
        ok = 1'b0;
        for (int n = 0; n < 100; n++) begin
            tick();
            if (!nIORQ) begin ok = 1'b1; break; end
        end
        chk("d_rerun_write", ok, 1);
        chk("d_rerun_addr", io_addr, 16'hBF3B);
        chk("d_rerun_idx", io_dout, 8'h00);
        wait_idle(2000, ok);
        chk("d_finish", ok, 1);
        tick();
        chk("d_writes", wr_count, 130);
        chk("d_palette", pal_errs(8'h33), 0);

        // ce every 4th clock
        ce_period = 4; exp_low = 8; exp_gap = 16; key = 8'hC6;
        clear_resp();
        pulse_start();
        wait_idle(4000, ok);
        chk("e_finish", ok, 1);
        tick();
        chk("e_writes", wr_count, 130);
        chk("e_low_len", low_bad, 0);
        chk("e_gap", gap_bad, 0);
        chk("e_stable", chg_bad, 0);
        chk("e_palette", pal_errs(8'hC6), 0);
        chk("e_done_cnt", done_cnt, 1);
        ce_period = 1; exp_low = 2; exp_gap = 5; ce = 1'b1;

        // second start while busy is ignored
        key = 8'h0F;
        clear_resp();
        pulse_start();
        tick(); tick(); tick();
        pulse_start();
        wait_idle(2000, ok);
        chk("f_finish", ok, 1);
        for (int n = 0; n < 6; n++) tick();
        chk("f_no_restart", busy, 0);
        chk("f_writes", wr_count, 130);
        chk("f_done_cnt", done_cnt, 1);

        // start + abort together in IDLE: start wins
        clear_resp();
        start = 1'b1; abort = 1'b1;
        tick();
        start = 1'b0; abort = 1'b0;
        wait_idle(2000, ok);
        chk("g_finish", ok, 1);
        chk("g_done", done, 1);
        tick();
        chk("g_writes", wr_count, 130);
        chk("g_aborted_cnt", aborted_cnt, 0);
        chk("g_done_cnt", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
